// File: rtl/mem_load_unit.sv
// MEM-stage load unit: fetches the aligned word over req/gnt/rvalid, extracts and extends
// the byte/half/word lane, and writes it back to the GPR file. One load in flight.
module mem_load_unit #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_size,
  input  logic              ld_unsigned,
  input  logic [REG_AW-1:0] ld_rd,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              ld_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [REG_AW-1:0]   rd_q, rd_d;

  logic                ld_ready_d, mem_req_d, wb_en_d, ld_err_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [REG_AW-1:0]   wb_rd_d;
  logic [DATA_W-1:0]   wb_data_d;

  logic                illegal_c;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [DATA_W-1:0]   lane_ext;

  assign illegal_c = (ld_size == 2'b11)
                   || ((ld_size == 2'b01) && ld_addr[0])
                   || ((ld_size == 2'b10) && (ld_addr[1:0] != 2'b00));

  // Lane extraction uses the captured request, not the live pipeline inputs
  always_comb begin
    byte_lane = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    half_lane = mem_rdata[{addr_lo_q[1], 4'b0000} +: 16];
    lane_ext  = mem_rdata;
    case (size_q)
      2'b00:   lane_ext = {{(DATA_W-8){byte_lane[7] & ~uns_q}}, byte_lane};
      2'b01:   lane_ext = {{(DATA_W-16){half_lane[15] & ~uns_q}}, half_lane};
      default: lane_ext = mem_rdata;
    endcase
  end

  // Next state and next registered outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_lo_d  = addr_lo_q;
    size_d     = size_q;
    uns_d      = uns_q;
    rd_d       = rd_q;
    mem_addr_d = mem_addr;
    wb_rd_d    = wb_rd;
    wb_data_d  = wb_data;
    mem_req_d  = 1'b0;
    wb_en_d    = 1'b0;
    ld_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ld_valid && ld_ready) begin
          addr_lo_d = ld_addr[1:0];
          size_d    = ld_size;
          uns_d     = ld_unsigned;
          rd_d      = ld_rd;
          if (illegal_c) begin
            state_d  = S_ERR;
            ld_err_d = 1'b1;
          end else begin
            state_d    = S_REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = {ld_addr[ADDR_W-1:2], 2'b00};
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d   = S_WB;
          wb_en_d   = (rd_q != '0);
          wb_rd_d   = rd_q;
          wb_data_d = lane_ext;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = S_ERR;
          ld_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ld_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_lo_q <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rd_q      <= '0;
      ld_ready  <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      ld_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_lo_q <= addr_lo_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      rd_q      <= rd_d;
      ld_ready  <= ld_ready_d;
      mem_req   <= mem_req_d;
      mem_addr  <= mem_addr_d;
      wb_en     <= wb_en_d;
      wb_rd     <= wb_rd_d;
      wb_data   <= wb_data_d;
      ld_err    <= ld_err_d;
    end
  end

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: aligned/misaligned loads, extension, handshake delays,
// timeout abort, rd=0 suppression and asynchronous reset mid-load.
module tb_mem_load_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic        ld_unsigned;
  logic [4:0]  ld_rd;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ld_err;

  int checks = 0;
  int errors = 0;
  int wb_cnt = 0;
  int err_cnt = 0;

  mem_load_unit dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_unsigned(ld_unsigned), .ld_rd(ld_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_en === 1'b1) wb_cnt++;
    if (ld_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a legal load; gdly cycles before gnt, rdly WAIT cycles before rvalid.
  // Leaves the bench in the WB cycle.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [4:0] rd, input int gdly, input int rdly,
                         input logic [31:0] rdata, input logic [31:0] exp_maddr);
    ld_valid = 1'b1; ld_addr = addr; ld_size = size; ld_unsigned = uns; ld_rd = rd;
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < gdly; i++) begin
      chk({tag, "_req_hold"}, 32'(mem_req), 32'd1);
      chk({tag, "_addr_hold"}, mem_addr, exp_maddr);
      tick();
    end
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_maddr"}, mem_addr, exp_maddr);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk({tag, "_req_drop"}, 32'(mem_req), 32'd0);
    for (int i = 0; i < rdly; i++) tick();
    mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0;
  endtask

  task automatic wb_check(input string tag, input logic en, input logic [4:0] rd,
                          input logic [31:0] data);
    chk({tag, "_wb_en"}, 32'(wb_en), 32'(en));
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, "_wb_data"}, wb_data, data);
    tick();
    chk({tag, "_wb_pulse"}, 32'(wb_en), 32'd0);
    chk({tag, "_ready"}, 32'(ld_ready), 32'd1);
  endtask

  initial begin
    int n;
    int wb_before;
    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_size = '0; ld_unsigned = 1'b0;
    ld_rd = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_wb_en", 32'(wb_en), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", 32'(ld_err), 32'd0);
    rst_n = 1'b1;
    tick(); tick();
    chk("idle_ready", 32'(ld_ready), 32'd1);

    // Word load, minimum latency
    do_load("word", 32'h10, 2'b10, 1'b0, 5'd5, 0, 0, 32'h8000_1234, 32'h10);
    wb_check("word", 1'b1, 5'd5, 32'h8000_1234);

    // Byte lane 3, signed then unsigned
    do_load("sbyte", 32'h13, 2'b00, 1'b0, 5'd7, 0, 0, 32'h80AA_BBCC, 32'h10);
    wb_check("sbyte", 1'b1, 5'd7, 32'hFFFF_FF80);
    do_load("ubyte", 32'h13, 2'b00, 1'b1, 5'd8, 0, 0, 32'h80AA_BBCC, 32'h10);
    wb_check("ubyte", 1'b1, 5'd8, 32'h0000_0080);
    do_load("byte1", 32'h11, 2'b00, 1'b0, 5'd9, 0, 0, 32'h80AA_BBCC, 32'h10);
    wb_check("byte1", 1'b1, 5'd9, 32'hFFFF_FFBB);

    // Halves
    do_load("half_hi", 32'h22, 2'b01, 1'b0, 5'd3, 0, 0, 32'h7FFF_8001, 32'h20);
    wb_check("half_hi", 1'b1, 5'd3, 32'h0000_7FFF);
    do_load("half_lo", 32'h20, 2'b01, 1'b0, 5'd4, 0, 0, 32'h7FFF_8001, 32'h20);
    wb_check("half_lo", 1'b1, 5'd4, 32'hFFFF_8001);
    do_load("uhalf_lo", 32'h20, 2'b01, 1'b1, 5'd4, 0, 0, 32'h7FFF_8001, 32'h20);
    wb_check("uhalf_lo", 1'b1, 5'd4, 32'h0000_8001);

    // Misaligned half and illegal size: one-cycle error, no RAM access
    wb_before = wb_cnt;
    ld_valid = 1'b1; ld_addr = 32'h21; ld_size = 2'b01; ld_rd = 5'd6;
    tick();
    ld_valid = 1'b0;
    chk("mis_err", 32'(ld_err), 32'd1);
    chk("mis_req", 32'(mem_req), 32'd0);
    tick();
    chk("mis_err_pulse", 32'(ld_err), 32'd0);
    chk("mis_ready", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1; ld_addr = 32'h40; ld_size = 2'b11;
    tick();
    ld_valid = 1'b0;
    chk("size11_err", 32'(ld_err), 32'd1);
    chk("size11_req", 32'(mem_req), 32'd0);
    tick();
    chk("size11_pulse", 32'(ld_err), 32'd0);
    chk("illegal_no_wb", 32'(wb_cnt), 32'(wb_before));

    // Delayed grant and rvalid
    wb_before = wb_cnt;
    do_load("slow", 32'h104, 2'b10, 1'b0, 5'd12, 3, 5, 32'hCAFE_F00D, 32'h104);
    wb_check("slow", 1'b1, 5'd12, 32'hCAFE_F00D);
    chk("slow_single_wb", 32'(wb_cnt - wb_before), 32'd1);

    // Timeout: grant, then no rvalid
    wb_before = wb_cnt;
    ld_valid = 1'b1; ld_addr = 32'h200; ld_size = 2'b10; ld_rd = 5'd2;
    tick();
    ld_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    n = 0;
    while (ld_err !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_seen", 32'(ld_err), 32'd1);
    checks++;
    assert (n >= 15 && n <= 17) else begin
      errors++;
      $error("FAIL tmo_cycles observed=%0d expected=15..17", n);
    end
    tick();
    chk("tmo_pulse", 32'(ld_err), 32'd0);
    chk("tmo_ready", 32'(ld_ready), 32'd1);
    chk("tmo_no_wb", 32'(wb_cnt), 32'(wb_before));

    // rd = 0: data driven, no write enable
    wb_before = wb_cnt;
    do_load("rd0", 32'h30, 2'b10, 1'b0, 5'd0, 0, 0, 32'h1234_5678, 32'h30);
    wb_check("rd0", 1'b0, 5'd0, 32'h1234_5678);
    chk("rd0_no_wb", 32'(wb_cnt), 32'(wb_before));

    // Asynchronous reset while waiting for rvalid
    wb_before = wb_cnt;
    ld_valid = 1'b1; ld_addr = 32'h50; ld_size = 2'b10; ld_rd = 5'd9;
    tick();
    ld_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ld_ready), 32'd0);
    chk("arst_maddr", mem_addr, 32'd0);
    chk("arst_wb_data", wb_data, 32'd0);
    chk("arst_wb_rd", 32'(wb_rd), 32'd0);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; mem_gnt = 1'b1;
    tick();
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    tick(); tick();
    chk("arst_no_wb", 32'(wb_cnt), 32'(wb_before));
    chk("arst_req", 32'(mem_req), 32'd0);
    chk("arst_ready_back", 32'(ld_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
